// File: rtl/writeback_stage_if.sv
// EX->WB boundary bundle for the writeback stage: EX-stage control and data,
// raw switch pins, register-file write port, HEX output and forwarding selects.
interface writeback_stage_if #(
  parameter int XLEN = 32
);
  logic            valid_EX;
  logic            regwrite_EX;
  logic [1:0]      regsel_EX;
  logic            gpio_we_EX;
  logic [4:0]      rd_EX;
  logic [4:0]      rs1_EX;
  logic [4:0]      rs2_EX;
  logic [XLEN-1:0] alu_r_EX;
  logic [19:0]     imm20_EX;
  logic [XLEN-1:0] gpio_wdata_EX;
  logic [XLEN-1:0] gpio_in;

  logic            regwrite_WB;
  logic [4:0]      rd_WB;
  logic [XLEN-1:0] writedata_WB;
  logic [XLEN-1:0] gpio_out;
  logic            fwd_a;
  logic            fwd_b;

  // EX side / core: drives the instruction bundle, consumes WB results
  modport master (
    output valid_EX, regwrite_EX, regsel_EX, gpio_we_EX, rd_EX, rs1_EX, rs2_EX,
           alu_r_EX, imm20_EX, gpio_wdata_EX, gpio_in,
    input  regwrite_WB, rd_WB, writedata_WB, gpio_out, fwd_a, fwd_b
  );

  // writeback stage
  modport slave (
    input  valid_EX, regwrite_EX, regsel_EX, gpio_we_EX, rd_EX, rs1_EX, rs2_EX,
           alu_r_EX, imm20_EX, gpio_wdata_EX, gpio_in,
    output regwrite_WB, rd_WB, writedata_WB, gpio_out, fwd_a, fwd_b
  );
endinterface

// File: rtl/writeback_stage.sv
// EX->WB pipeline register of the 3-stage RV32 core. Selects and registers the
// writeback value, qualifies the register-file write, owns the HEX output
// register and the switch synchronizer, and produces WB->EX forwarding selects.
module writeback_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] GPIO_RST = '0
) (
  input logic             clk,
  input logic             rst,
  writeback_stage_if.slave bus
);

  logic [XLEN-1:0] sync1;
  logic [XLEN-1:0] sync2;
  logic [XLEN-1:0] wb_data_next;
  logic            regwrite_next;
  logic            gpio_load;
  logic            regwrite_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] writedata_q;
  logic [XLEN-1:0] gpio_q;

  // Two-flop synchronizer on the asynchronous switch pins, nothing between flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.gpio_in;
      sync2 <= sync1;
    end
  end

  // Writeback source select and write qualification, evaluated during EX.
  // Case-equality makes an X/Z controller bit behave as 0 in simulation.
  always_comb begin
    wb_data_next = '0;
    case (bus.regsel_EX)
      2'b00:   wb_data_next = sync2;
      2'b01:   wb_data_next = {bus.imm20_EX, {(XLEN-20){1'b0}}};
      2'b10:   wb_data_next = bus.alu_r_EX;
      default: wb_data_next = '0;
    endcase
    regwrite_next = bus.valid_EX & (bus.regwrite_EX === 1'b1) & (bus.rd_EX != 5'd0);
    gpio_load     = bus.valid_EX & (bus.gpio_we_EX === 1'b1);
  end

  // EX->WB register; address/data load every edge, only the enable is qualified
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_q  <= 1'b0;
      rd_q        <= 5'd0;
      writedata_q <= '0;
    end else begin
      regwrite_q  <= regwrite_next;
      rd_q        <= bus.rd_EX;
      writedata_q <= wb_data_next;
    end
  end

  // HEX display register written by csrrw, holds otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_q <= GPIO_RST;
    end else if (gpio_load) begin
      gpio_q <= bus.gpio_wdata_EX;
    end
  end

  // rd_q is never 0 while regwrite_q is set, so x0 sources never forward
  assign bus.fwd_a        = regwrite_q & (rd_q == bus.rs1_EX);
  assign bus.fwd_b        = regwrite_q & (rd_q == bus.rs2_EX);
  assign bus.regwrite_WB  = regwrite_q;
  assign bus.rd_WB        = rd_q;
  assign bus.writedata_WB = writedata_q;
  assign bus.gpio_out     = gpio_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed steps followed by random
// instructions compared against a behavioural model of the EX->WB boundary.
module tb_writeback_stage;
  localparam int          XLEN     = 32;
  localparam logic [31:0] GPIO_RST = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  writeback_stage_if #(.XLEN(XLEN)) bus ();

  writeback_stage #(.XLEN(XLEN), .GPIO_RST(GPIO_RST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: what the WB stage should present, plus switch samples taken at
  // previous edges (index 0 = last edge, index 1 = the edge before).
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic [31:0] m_gpio;
  logic [31:0] sw_hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_we   = 1'b0;
    m_rd   = 5'd0;
    m_wd   = 32'h0;
    m_gpio = GPIO_RST;
    sw_hist = '{32'h0, 32'h0};
  endtask

  // What one rising edge does to the architectural state
  task automatic model_edge();
    logic [31:0] sw_seen;
    sw_seen = sw_hist[1];
    case (bus.regsel_EX)
      2'd0: m_wd = sw_seen;
      2'd1: m_wd = bus.imm20_EX * 32'h1000;
      2'd2: m_wd = bus.alu_r_EX;
      default: m_wd = 32'h0;
    endcase
    m_rd = bus.rd_EX;
    m_we = bus.valid_EX && bus.regwrite_EX && (bus.rd_EX != 0);
    if (bus.valid_EX && bus.gpio_we_EX) m_gpio = bus.gpio_wdata_EX;
    sw_hist.push_front(bus.gpio_in);
    void'(sw_hist.pop_back());
  endtask

  task automatic check_regs();
    chk("regwrite_WB", {31'b0, bus.regwrite_WB}, {31'b0, m_we});
    if (m_we) begin
      chk("rd_WB", {27'b0, bus.rd_WB}, {27'b0, m_rd});
      chk("writedata_WB", bus.writedata_WB, m_wd);
    end
    chk("gpio_out", bus.gpio_out, m_gpio);
  endtask

  task automatic check_fwd();
    chk("fwd_a", {31'b0, bus.fwd_a}, {31'b0, m_we && (m_rd == bus.rs1_EX)});
    chk("fwd_b", {31'b0, bus.fwd_b}, {31'b0, m_we && (m_rd == bus.rs2_EX)});
  endtask

  // Present one EX instruction, check forwarding against the current WB
  // contents, then clock it into WB and check the registered outputs.
  task automatic op(input logic v, input logic rw, input logic [1:0] sel,
                    input logic gwe, input logic [4:0] rd, input logic [4:0] rs1,
                    input logic [4:0] rs2, input logic [31:0] alu,
                    input logic [19:0] imm, input logic [31:0] gwd);
    bus.valid_EX      = v;
    bus.regwrite_EX   = rw;
    bus.regsel_EX     = sel;
    bus.gpio_we_EX    = gwe;
    bus.rd_EX         = rd;
    bus.rs1_EX        = rs1;
    bus.rs2_EX        = rs2;
    bus.alu_r_EX      = alu;
    bus.imm20_EX      = imm;
    bus.gpio_wdata_EX = gwd;
    #1;
    check_fwd();
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  initial begin
    bus.valid_EX = 0; bus.regwrite_EX = 0; bus.regsel_EX = 0; bus.gpio_we_EX = 0;
    bus.rd_EX = 0; bus.rs1_EX = 0; bus.rs2_EX = 0; bus.alu_r_EX = 0;
    bus.imm20_EX = 0; bus.gpio_wdata_EX = 0; bus.gpio_in = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check_regs();
    check_fwd();
    chk("rst_writedata", bus.writedata_WB, 32'h0);
    chk("rst_rd", {27'b0, bus.rd_WB}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // addi x5
    op(1, 1, 2'd2, 0, 5'd5, 5'd1, 5'd2, 32'h0000_002A, 20'h0, 32'h0);
    chk("addi_wd", bus.writedata_WB, 32'h0000_002A);
    chk("addi_rd", {27'b0, bus.rd_WB}, 32'd5);
    // lui x7, 0xABCDE
    op(1, 1, 2'd1, 0, 5'd7, 5'd0, 5'd0, 32'h0, 20'hABCDE, 32'h0);
    chk("lui_wd", bus.writedata_WB, 32'hABCD_E000);

    // Switch read: pins change before edge A; csrrw at A and A+1 see 0,
    // at A+2 sees the new value.
    bus.gpio_in = 32'h0001_2345;
    op(1, 1, 2'd0, 0, 5'd9, 5'd0, 5'd0, 32'h0, 20'h0, 32'h0);
    chk("sw_early", bus.writedata_WB, 32'h0);
    op(1, 1, 2'd0, 0, 5'd9, 5'd0, 5'd0, 32'h0, 20'h0, 32'h0);
    chk("sw_mid", bus.writedata_WB, 32'h0);
    op(1, 1, 2'd0, 0, 5'd9, 5'd0, 5'd0, 32'h0, 20'h0, 32'h0);
    chk("sw_new", bus.writedata_WB, 32'h0001_2345);

    // HEX write, then same write as a bubble
    op(1, 0, 2'd0, 1, 5'd0, 5'd0, 5'd0, 32'h0, 20'h0, 32'hDEAD_BEEF);
    chk("hex_write", bus.gpio_out, 32'hDEAD_BEEF);
    op(0, 0, 2'd0, 1, 5'd0, 5'd0, 5'd0, 32'h0, 20'h0, 32'h1234_5678);
    chk("hex_bubble", bus.gpio_out, 32'hDEAD_BEEF);
    // Both regwrite and HEX write in one instruction
    op(1, 1, 2'd2, 1, 5'd12, 5'd0, 5'd0, 32'h55, 20'h0, 32'hCAFE_0001);
    chk("both_gpio", bus.gpio_out, 32'hCAFE_0001);

    // Forwarding: producer x3 in WB, consumer rs1=3 rs2=4 in EX
    op(1, 1, 2'd2, 0, 5'd3, 5'd0, 5'd0, 32'h77, 20'h0, 32'h0);
    op(1, 1, 2'd3, 0, 5'd0, 5'd3, 5'd4, 32'h0, 20'h0, 32'h0);
    // x0 destination was just written with regwrite=1: no enable, no forward of x0
    chk("x0_regwrite", {31'b0, bus.regwrite_WB}, 32'h0);
    op(1, 0, 2'd2, 0, 5'd0, 5'd0, 5'd0, 32'h0, 20'h0, 32'h0);
    chk("x0_fwd_a", {31'b0, bus.fwd_a}, 32'h0);

    // Mid-stream reset with a write in flight
    op(1, 1, 2'd2, 0, 5'd8, 5'd8, 5'd0, 32'h99, 20'h0, 32'h0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_regs();
    check_fwd();
    @(negedge clk);
    rst = 1'b0;
    bus.gpio_in = 32'h0;
    op(0, 1, 2'd2, 0, 5'd8, 5'd8, 5'd0, 32'h99, 20'h0, 32'h0);
    chk("post_rst_no_write", {31'b0, bus.regwrite_WB}, 32'h0);

    // Random instruction stream
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) bus.gpio_in = $urandom;
      op($urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0,
         2'($urandom_range(0, 3)), $urandom_range(0, 5) == 0,
         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
         5'($urandom_range(0, 7)), $urandom, 20'($urandom), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
